// File: rtl/spc_reg_file_p.sv
// spc_reg_file_p
//   Parametrised special-register file for the single-cycle computer.
//   Holds ZR/SP/LR/PC/CPSR plus optional scratch registers (index >= 8), with
//   hardware PC sequencing, branch-with-link, bounded SP push/pop, NZCV flag
//   update and two combinational user read ports. All state is clocked.
//
//   Index map: 0 ZR, 1-3 reserved (plain R/W), 4 SP, 5 LR, 6 PC, 7 CPSR.
//
// Ports
//   clk                   clock, all updates on the rising edge
//   reset                 asynchronous active-low reset
//   rd_addr_a/rd_data_a   user read port A (combinational, pre-edge value)
//   rd_addr_b/rd_data_b   user read port B (combinational, pre-edge value)
//   wr_en/wr_addr/wr_data user write port
//   pc_inc                advance PC by PC_STEP
//   br_valid/br_target    load PC from br_target
//   br_link               with br_valid: LR <= PC + PC_STEP (pre-edge PC)
//   sp_push/sp_pop        SP -/+ SP_STEP with bounds check
//   flags_we/flags_in     load CPSR[DATA_W-1:DATA_W-4] with N,Z,C,V
//   fault_clr             clear sticky sp_fault
//   pc/sp/lr/cpsr         direct views of the special registers
//   sp_fault              sticky stack over/underflow indicator
//
// There is no request/response handshake on this block: every strobe is a
// single-cycle command that takes effect on the next rising edge.
module spc_reg_file_p #(
  parameter int               DATA_W   = 32,
  parameter int               NUM_REGS = 8,
  parameter int               ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned      PC_STEP  = 4,
  parameter int unsigned      SP_STEP  = 4,
  parameter logic [DATA_W-1:0] SP_TOP  = 'h0000_1000,
  parameter logic [DATA_W-1:0] SP_BOT  = 'h0000_0800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pc_inc,
  input  logic              br_valid,
  input  logic [DATA_W-1:0] br_target,
  input  logic              br_link,
  input  logic              sp_push,
  input  logic              sp_pop,
  input  logic              flags_we,
  input  logic [3:0]        flags_in,
  input  logic              fault_clr,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] sp,
  output logic [DATA_W-1:0] lr,
  output logic [DATA_W-1:0] cpsr,
  output logic              sp_fault
);

  localparam int IDX_ZR   = 0;
  localparam int IDX_SP   = 4;
  localparam int IDX_LR   = 5;
  localparam int IDX_PC   = 6;
  localparam int IDX_CPSR = 7;

  localparam logic [DATA_W-1:0] PC_INC_V = DATA_W'(PC_STEP);
  localparam logic [DATA_W-1:0] SP_INC_V = DATA_W'(SP_STEP);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              sp_fault_q, sp_fault_d;

  logic user_wr;
  logic wr_pc;
  logic push_only, pop_only;
  logic push_bad, pop_bad;
  logic fault_set;

  // ZR storage is never written, but reads are gated as well so the
  // zero guarantee does not depend on that.
  assign rd_data_a = (int'(rd_addr_a) == IDX_ZR) ? '0 : regs_q[rd_addr_a];
  assign rd_data_b = (int'(rd_addr_b) == IDX_ZR) ? '0 : regs_q[rd_addr_b];

  assign pc       = regs_q[IDX_PC];
  assign sp       = regs_q[IDX_SP];
  assign lr       = regs_q[IDX_LR];
  assign cpsr     = regs_q[IDX_CPSR];
  assign sp_fault = sp_fault_q;

  assign user_wr   = wr_en && (int'(wr_addr) != IDX_ZR);
  assign wr_pc     = wr_en && (int'(wr_addr) == IDX_PC);
  assign push_only = sp_push && !sp_pop;
  assign pop_only  = sp_pop && !sp_push;
  // Bounds compared without forming SP-STEP / SP+STEP so wrap cannot hide a fault.
  assign push_bad  = regs_q[IDX_SP] < (SP_BOT + SP_INC_V);
  assign pop_bad   = regs_q[IDX_SP] > (SP_TOP - SP_INC_V);
  assign fault_set = (push_only && push_bad) || (pop_only && pop_bad);

  always_comb begin
    regs_d     = regs_q;
    sp_fault_d = sp_fault_q;

    // Generic user write first; special-register rules below override it.
    if (user_wr) regs_d[wr_addr] = wr_data;

    // PC: branch > user write > increment > hold.
    if (br_valid)            regs_d[IDX_PC] = br_target;
    else if (!wr_pc && pc_inc) regs_d[IDX_PC] = regs_q[IDX_PC] + PC_INC_V;

    // Link uses the pre-edge PC and beats a user write to LR.
    if (br_valid && br_link) regs_d[IDX_LR] = regs_q[IDX_PC] + PC_INC_V;

    // Any stack op owns SP for the cycle, including push+pop (net no change).
    if (sp_push || sp_pop) regs_d[IDX_SP] = regs_q[IDX_SP];
    if (push_only && !push_bad) regs_d[IDX_SP] = regs_q[IDX_SP] - SP_INC_V;
    if (pop_only  && !pop_bad)  regs_d[IDX_SP] = regs_q[IDX_SP] + SP_INC_V;

    // Flags overlay the top nibble of whatever CPSR would otherwise become.
    if (flags_we) regs_d[IDX_CPSR][DATA_W-1 -: 4] = flags_in;

    if (fault_clr) sp_fault_d = 1'b0;
    if (fault_set) sp_fault_d = 1'b1;

    regs_d[IDX_ZR] = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      regs_q[IDX_SP] <= SP_TOP;
      sp_fault_q     <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      sp_fault_q <= sp_fault_d;
    end
  end

endmodule

// File: tb/tb_spc_reg_file_p.sv
module tb_spc_reg_file_p;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [DATA_W-1:0] rd_data_a, rd_data_b, wr_data, br_target;
  logic              wr_en, pc_inc, br_valid, br_link, sp_push, sp_pop;
  logic              flags_we, fault_clr;
  logic [3:0]        flags_in;
  logic [DATA_W-1:0] pc, sp, lr, cpsr;
  logic              sp_fault;

  int total = 0;
  int bad   = 0;

  spc_reg_file_p #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_inc(pc_inc), .br_valid(br_valid), .br_target(br_target), .br_link(br_link),
    .sp_push(sp_push), .sp_pop(sp_pop),
    .flags_we(flags_we), .flags_in(flags_in), .fault_clr(fault_clr),
    .pc(pc), .sp(sp), .lr(lr), .cpsr(cpsr), .sp_fault(sp_fault)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    wr_en = 0; wr_addr = '0; wr_data = '0;
    pc_inc = 0; br_valid = 0; br_target = '0; br_link = 0;
    sp_push = 0; sp_pop = 0; flags_we = 0; flags_in = '0; fault_clr = 0;
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic user_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    idle();
    wr_en = 1; wr_addr = a; wr_data = d;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rd_addr_a = '0; rd_addr_b = '0;
    reset = 0;
    step(); step();
    total++; if (pc !== 32'h0)         begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (sp !== 32'h1000)      begin bad++; $display("FAIL reset_sp got=%h exp=%h", sp, 32'h1000); end
    total++; if (lr !== 32'h0)         begin bad++; $display("FAIL reset_lr got=%h exp=%h", lr, 32'h0); end
    total++; if (cpsr !== 32'h0)       begin bad++; $display("FAIL reset_cpsr got=%h exp=%h", cpsr, 32'h0); end
    total++; if (sp_fault !== 1'b0)    begin bad++; $display("FAIL reset_fault got=%b exp=0", sp_fault); end
    @(negedge clk);
    reset = 1;
    step();
    pc_inc = 1;
    step(); step(); step();
    idle();
    total++; if (pc !== 32'd12)        begin bad++; $display("FAIL pc_inc3 got=%h exp=%h", pc, 32'd12); end
  endtask

  task automatic test_branch();
    user_write(4'd6, 32'd8);
    total++; if (pc !== 32'd8)         begin bad++; $display("FAIL pc_write got=%h exp=%h", pc, 32'd8); end
    // br_link without br_valid: LR untouched, PC just increments
    br_link = 1; pc_inc = 1;
    step(); idle();
    total++; if (lr !== 32'h0)         begin bad++; $display("FAIL link_no_br got=%h exp=%h", lr, 32'h0); end
    total++; if (pc !== 32'd12)        begin bad++; $display("FAIL pc_inc_link got=%h exp=%h", pc, 32'd12); end
    user_write(4'd6, 32'd8);
    br_valid = 1; br_link = 1; br_target = 32'h40; pc_inc = 1;
    wr_en = 1; wr_addr = 4'd6; wr_data = 32'h77;
    step(); idle();
    total++; if (pc !== 32'h40)        begin bad++; $display("FAIL br_pc got=%h exp=%h", pc, 32'h40); end
    total++; if (lr !== 32'hC)         begin bad++; $display("FAIL br_lr got=%h exp=%h", lr, 32'hC); end
    // Link beats user write to LR; user write beats pc_inc
    user_write(4'd6, 32'h100);
    br_valid = 1; br_link = 1; br_target = 32'h200;
    wr_en = 1; wr_addr = 4'd5; wr_data = 32'h5555;
    step(); idle();
    total++; if (lr !== 32'h104)       begin bad++; $display("FAIL link_vs_wr got=%h exp=%h", lr, 32'h104); end
    wr_en = 1; wr_addr = 4'd6; wr_data = 32'h300; pc_inc = 1;
    step(); idle();
    total++; if (pc !== 32'h300)       begin bad++; $display("FAIL wr_vs_inc got=%h exp=%h", pc, 32'h300); end
    // PC wraps
    user_write(4'd6, 32'hFFFF_FFFC);
    pc_inc = 1; step(); idle();
    total++; if (pc !== 32'h0)         begin bad++; $display("FAIL pc_wrap got=%h exp=%h", pc, 32'h0); end
  endtask

  task automatic test_stack();
    user_write(4'd4, 32'h804);
    sp_push = 1; step(); idle();
    total++; if (sp !== 32'h800)       begin bad++; $display("FAIL push got=%h exp=%h", sp, 32'h800); end
    total++; if (sp_fault !== 1'b0)    begin bad++; $display("FAIL push_nofault got=%b exp=0", sp_fault); end
    sp_push = 1; step(); idle();
    total++; if (sp !== 32'h800)       begin bad++; $display("FAIL push_full got=%h exp=%h", sp, 32'h800); end
    total++; if (sp_fault !== 1'b1)    begin bad++; $display("FAIL push_fault got=%b exp=1", sp_fault); end
    step();
    total++; if (sp_fault !== 1'b1)    begin bad++; $display("FAIL fault_sticky got=%b exp=1", sp_fault); end
    fault_clr = 1; step(); idle();
    total++; if (sp_fault !== 1'b0)    begin bad++; $display("FAIL fault_clr got=%b exp=0", sp_fault); end
    sp_push = 1; sp_pop = 1; step(); idle();
    total++; if (sp !== 32'h800)       begin bad++; $display("FAIL push_pop got=%h exp=%h", sp, 32'h800); end
    sp_pop = 1; wr_en = 1; wr_addr = 4'd4; wr_data = 32'h900; step(); idle();
    total++; if (sp !== 32'h804)       begin bad++; $display("FAIL pop_vs_wr got=%h exp=%h", sp, 32'h804); end
    rd_addr_a = 4'd4; #1;
    total++; if (rd_data_a !== 32'h804) begin bad++; $display("FAIL rd_sp got=%h exp=%h", rd_data_a, 32'h804); end
    // Pop past top faults; set beats clear in the same cycle
    user_write(4'd4, 32'h1000);
    sp_pop = 1; fault_clr = 1; step(); idle();
    total++; if (sp !== 32'h1000)      begin bad++; $display("FAIL pop_empty got=%h exp=%h", sp, 32'h1000); end
    total++; if (sp_fault !== 1'b1)    begin bad++; $display("FAIL set_vs_clr got=%b exp=1", sp_fault); end
    fault_clr = 1; step(); idle();
  endtask

  task automatic test_user_regs();
    user_write(4'd0, 32'hFFFF);
    rd_addr_a = 4'd0; #1;
    total++; if (rd_data_a !== 32'h0)  begin bad++; $display("FAIL zr_read got=%h exp=%h", rd_data_a, 32'h0); end
    rd_addr_b = 4'd9;
    wr_en = 1; wr_addr = 4'd9; wr_data = 32'hAA; #1;
    total++; if (rd_data_b !== 32'h0)  begin bad++; $display("FAIL no_bypass got=%h exp=%h", rd_data_b, 32'h0); end
    step(); idle();
    total++; if (rd_data_b !== 32'hAA) begin bad++; $display("FAIL scratch9 got=%h exp=%h", rd_data_b, 32'hAA); end
    user_write(4'd2, 32'h1234_5678);
    rd_addr_a = 4'd2; #1;
    total++; if (rd_data_a !== 32'h1234_5678) begin bad++; $display("FAIL reserved2 got=%h exp=%h", rd_data_a, 32'h1234_5678); end
  endtask

  task automatic test_flags();
    wr_en = 1; wr_addr = 4'd7; wr_data = 32'h0000_0001;
    flags_we = 1; flags_in = 4'b1010;
    step(); idle();
    total++; if (cpsr !== 32'hA000_0001) begin bad++; $display("FAIL cpsr_wr_flags got=%h exp=%h", cpsr, 32'hA000_0001); end
    flags_we = 1; flags_in = 4'b0101;
    step(); idle();
    total++; if (cpsr !== 32'h5000_0001) begin bad++; $display("FAIL flags_only got=%h exp=%h", cpsr, 32'h5000_0001); end
  endtask

  task automatic test_async_reset();
    user_write(4'd4, 32'hFF8);
    user_write(4'd6, 32'h100);
    user_write(4'd5, 32'h44);
    total++; if (sp !== 32'hFF8 || pc !== 32'h100) begin bad++; $display("FAIL pre_reset sp=%h pc=%h exp sp=ff8 pc=100", sp, pc); end
    #2;
    reset = 0;
    #1;
    total++; if (pc !== 32'h0)         begin bad++; $display("FAIL async_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (sp !== 32'h1000)      begin bad++; $display("FAIL async_sp got=%h exp=%h", sp, 32'h1000); end
    total++; if (lr !== 32'h0)         begin bad++; $display("FAIL async_lr got=%h exp=%h", lr, 32'h0); end
    // Ops ignored while held in reset
    pc_inc = 1; sp_push = 1;
    step();
    total++; if (pc !== 32'h0 || sp !== 32'h1000) begin bad++; $display("FAIL held_reset pc=%h sp=%h exp pc=0 sp=1000", pc, sp); end
    #2;
    reset = 1;
    #1;
    total++; if (pc !== 32'h0)         begin bad++; $display("FAIL release_nochange got=%h exp=%h", pc, 32'h0); end
    sp_push = 0;
    step(); idle();
    total++; if (pc !== 32'h4)         begin bad++; $display("FAIL post_release got=%h exp=%h", pc, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stack();
    test_user_regs();
    test_flags();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
